result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
- Parametrised successor to the fixed 3072-bit result-to-FIFO writer.
- Accepts one wide result vector per valid/ready handshake and slices it into WORD_W words, LSB word first.
- Pushes the words into an internal synchronous FIFO that the downstream host/bus interface drains with rd_req.
- Adds backpressure on FIFO full, an accept handshake, a fill-level output and read-underflow detection.

Parameters:
- RESULT_W, 3072, width of the input result vector; must be an integer multiple of WORD_W (elaboration error otherwise).
- WORD_W, 32, output word width.
- FIFO_DEPTH, 64, FIFO entries; power of two, at least 2.
- NWORDS (localparam), RESULT_W/WORD_W, words per result.
- AW (localparam), clog2(FIFO_DEPTH), FIFO pointer width.

Ports:
- clk_in  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- result  in  RESULT_W  result vector; sampled only on accept.
- result_valid  in  1  result is present.
- result_ready  out  1  block can accept a result (high only in IDLE).
- rd_req  in  1  pop one word from the FIFO.
- out_data  out  WORD_W  popped word, registered.
- fifo_empty  out  1  FIFO holds 0 words.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_level  out  AW+1  current FIFO occupancy.
- busy  out  1  serialisation in progress (state SHIFT).
- underflow  out  1  sticky; set by rd_req while fifo_empty.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE; cache, word counter and FIFO pointers clear.
  - out_data=0, fifo_empty=1, fifo_full=0, fifo_level=0, busy=0, underflow=0, result_ready=1.
- FSM IDLE:
  - result_ready=1.
  - Accept when result_valid && result_ready: cache<=result, word_cnt<=0, go to SHIFT.
- FSM SHIFT:
  - result_ready=0, busy=1.
  - Each cycle with !fifo_full: write cache[WORD_W-1:0], shift cache right by WORD_W, word_cnt+1.
  - On the write with word_cnt==NWORDS-1, go to IDLE; the next result can be accepted in the following cycle.
  - While fifo_full: stall. Cache and counter hold; no write.
  - A simultaneous rd_req does not permit a write into a full FIFO in that cycle.
- Latency:
  - Accept at edge T; first FIFO write at edge T+1; fifo_empty falls after edge T+1.
  - With no stalls, the last word is written at edge T+NWORDS.
  - Throughput: one result per NWORDS+1 cycles.
- FIFO (non-show-ahead):
  - rd_req with !fifo_empty pops; out_data updates at that edge and holds until the next pop.
  - rd_req while empty: ignored, pointers unchanged, out_data holds, underflow<=1 (cleared only by reset).
  - Simultaneous push and pop: fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_full/empty are derived from fifo_level.
- Reset mid-serialisation: the partial result is discarded and the FIFO contents are lost.
- result is never re-sampled during SHIFT, so the producer may change it after the accept.

Optional Feature:
- Macro: RESULT_SER_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit, reset 0).
  - The FIFO stores WORD_W+1 bits per entry.
  - The extra bit is set on the final word (word_cnt==NWORDS-1) of each result.
  - out_last is registered alongside out_data on each pop.
- Undefined:
  - No out_last port.
  - FIFO entry width is WORD_W.
  - Behaviour is otherwise identical.

Decomposition:
- Package result_ser_pkg:
  - FSM state enum (ST_IDLE, ST_SHIFT).
  - Function clog2.
  - Default constants RESULT_W_DEF=3072, WORD_W_DEF=32, FIFO_DEPTH_DEF=64.
- Sub-module sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: clk_in, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level.
  - Instantiated once; the top level holds only the FSM, cache and counter.

Test Plan (RESULT_W=96, WORD_W=32, FIFO_DEPTH=4 unless noted):
- Reset release, no stimulus -> result_ready=1, fifo_empty=1, fifo_level=0, out_data=0, underflow=0.
- Accept result 0x33333333_22222222_11111111, then pop 3 times -> out_data 0x11111111, 0x22222222, 0x33333333; fifo_empty=1 after the last pop; accept to first write takes 1 cycle.
- Offer two results back-to-back with no reads -> FIFO reaches level 4 with fifo_full=1 and the FSM stalls holding word 2 of result 2; one pop -> the stalled word is written the next cycle; result_ready stays 0 until word 3 is written.
- rd_req while empty -> underflow=1, out_data unchanged, fifo_level=0; underflow stays set through later traffic until rst_n is asserted.
- Assert rst_n low mid-SHIFT after word 1 -> all outputs at reset values immediately (asynchronous); after release, a new result serialises from its word 0.
- Defaults (3072/32/64) with RESULT_SER_LAST_EN defined -> 96 words per result; out_last=1 only on word 96; level 64 is reached with fifo_full asserted exactly there.

Source files
------------

// File: rtl/result_ser_pkg.sv
// Shared types, defaults and helpers for the result serializer.
// Optional final-word flag is enabled by defining RESULT_SER_LAST_EN.
package result_ser_pkg;

  localparam int unsigned RESULT_W_DEF   = 3072;
  localparam int unsigned WORD_W_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 64;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/result_serializer_sync_fifo.sv
// Synchronous non-show-ahead FIFO with registered read data and occupancy count.
// Full/empty are derived from the level counter.
module sync_fifo
  import result_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             push, pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign level   = level_q;

endmodule

// File: rtl/result_serializer.sv
// Accepts a wide result per handshake, slices it LSB-word-first into an internal FIFO.
// Define RESULT_SER_LAST_EN to add out_last, flagging the final word of each result.
module result_serializer
  import result_ser_pkg::*;
#(
  parameter int unsigned RESULT_W   = RESULT_W_DEF,
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int unsigned NWORDS    = RESULT_W / WORD_W,
  localparam int unsigned AW        = clog2(FIFO_DEPTH)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [RESULT_W-1:0] result,
  input  logic                result_valid,
  output logic                result_ready,
  input  logic                rd_req,
  output logic [WORD_W-1:0]   out_data,
  output logic                fifo_empty,
  output logic                fifo_full,
  output logic [AW:0]         fifo_level,
  output logic                busy,
  output logic                underflow
`ifdef RESULT_SER_LAST_EN
  ,
  output logic                out_last
`endif
);

  localparam int unsigned CW = clog2(NWORDS + 1);
`ifdef RESULT_SER_LAST_EN
  localparam int unsigned EW = WORD_W + 1;
`else
  localparam int unsigned EW = WORD_W;
`endif

  if (WORD_W == 0 || RESULT_W == 0 || (RESULT_W % WORD_W) != 0) begin : g_bad_width
    $error("RESULT_W must be a non-zero integer multiple of WORD_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  state_e              state_q, state_d;
  logic [RESULT_W-1:0] cache_q, cache_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_en, last_word;
  logic [EW-1:0]       wr_data, rd_data;
  logic                underflow_q;

  assign last_word = (cnt_q == CW'(NWORDS - 1));

  always_comb begin
    state_d      = state_q;
    cache_d      = cache_q;
    cnt_d        = cnt_q;
    wr_en        = 1'b0;
    result_ready = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        result_ready = 1'b1;
        if (result_valid) begin
          cache_d = result;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        // Full FIFO stalls even when a pop happens in the same cycle.
        if (!fifo_full) begin
          wr_en   = 1'b1;
          cache_d = cache_q >> WORD_W;
          cnt_d   = cnt_q + 1'b1;
          if (last_word) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cache_q     <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cache_q <= cache_d;
      cnt_q   <= cnt_d;
      if (rd_req && fifo_empty) underflow_q <= 1'b1;
    end
  end

`ifdef RESULT_SER_LAST_EN
  assign wr_data  = {last_word, cache_q[WORD_W-1:0]};
  assign out_data = rd_data[WORD_W-1:0];
  assign out_last = rd_data[WORD_W];
`else
  assign wr_data  = cache_q[WORD_W-1:0];
  assign out_data = rd_data;
`endif

  assign underflow = underflow_q;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_req),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_result_serializer.sv
// Directed self-checking bench for result_serializer with a 96/32/4 configuration.
module tb_result_serializer;

  localparam int unsigned RW = 96;
  localparam int unsigned WW = 32;
  localparam int unsigned FD = 4;

  logic          clk_in = 1'b0;
  logic          rst_n;
  logic [RW-1:0] result;
  logic          result_valid;
  logic          result_ready;
  logic          rd_req;
  logic [WW-1:0] out_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          underflow;
`ifdef RESULT_SER_LAST_EN
  logic          out_last;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  result_serializer #(
    .RESULT_W   (RW),
    .WORD_W     (WW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .rd_req       (rd_req),
    .out_data     (out_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .underflow    (underflow)
`ifdef RESULT_SER_LAST_EN
    ,
    .out_last     (out_last)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkl(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; result = '0; result_valid = 1'b0; rd_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk1("reset_ready", result_ready, 1'b1);
    chk1("reset_empty", fifo_empty, 1'b1);
    chk1("reset_full", fifo_full, 1'b0);
    chkl("reset_level", fifo_level, 3'd0);
    chkw("reset_data", out_data, '0);
    chk1("reset_underflow", underflow, 1'b0);
    chk1("reset_busy", busy, 1'b0);
  endtask

  task automatic test_basic();
    logic [WW-1:0] exp_w [3];
    exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333;
    result = 96'h33333333_22222222_11111111;
    result_valid = 1'b1;
    cyc(1);                                   // accept edge T
    result_valid = 1'b0;
    result = '1;                              // must not be re-sampled
    chk1("basic_busy", busy, 1'b1);
    chk1("basic_ready_low", result_ready, 1'b0);
    chk1("basic_empty_at_T", fifo_empty, 1'b1);
    cyc(1);                                   // T+1: first write
    chk1("basic_empty_T1", fifo_empty, 1'b0);
    chkl("basic_level_T1", fifo_level, 3'd1);
    cyc(2);                                   // T+3: last write
    chkl("basic_level_T3", fifo_level, 3'd3);
    chk1("basic_ready_T3", result_ready, 1'b1);
    chk1("basic_idle_T3", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      cyc(1);
      chkw($sformatf("basic_pop%0d", i), out_data, exp_w[i]);
      chkl($sformatf("basic_pop%0d_level", i), fifo_level, 3'(2 - i));
`ifdef RESULT_SER_LAST_EN
      chk1($sformatf("basic_pop%0d_last", i), out_last, (i == 2));
`endif
    end
    rd_req = 1'b0;
    chk1("basic_empty_end", fifo_empty, 1'b1);
    cyc(1);
    chkw("basic_data_hold", out_data, 32'h33333333);
  endtask

  task automatic test_underflow();
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
    chk1("uf_set", underflow, 1'b1);
    chkw("uf_data_hold", out_data, 32'h33333333);
    chkl("uf_level", fifo_level, 3'd0);
    chk1("uf_empty", fifo_empty, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] exp_w [4];
    exp_w[0] = 32'hA3A3A3A3; exp_w[1] = 32'hB1B1B1B1;
    exp_w[2] = 32'hB2B2B2B2; exp_w[3] = 32'hB3B3B3B3;
    result = 96'hA3A3A3A3_A2A2A2A2_A1A1A1A1;
    result_valid = 1'b1;
    cyc(1);                                   // A accepted at T0
    result = 96'hB3B3B3B3_B2B2B2B2_B1B1B1B1;
    cyc(3);                                   // T0+3: A done, IDLE
    chkl("b2b_level_A", fifo_level, 3'd3);
    chk1("b2b_ready_gap", result_ready, 1'b1);
    cyc(1);                                   // B accepted at T0+4
    result_valid = 1'b0;
    chk1("b2b_busy_B", busy, 1'b1);
    cyc(1);                                   // B1 written, FIFO full
    chkl("b2b_level_full", fifo_level, 3'd4);
    chk1("b2b_full", fifo_full, 1'b1);
    cyc(2);
    chkl("b2b_stall_level", fifo_level, 3'd4);
    chk1("b2b_stall_busy", busy, 1'b1);
    chk1("b2b_stall_ready", result_ready, 1'b0);
    rd_req = 1'b1;
    cyc(1);                                   // pop while full: no write this edge
    rd_req = 1'b0;
    chkl("b2b_pop_level", fifo_level, 3'd3);
    chk1("b2b_pop_notfull", fifo_full, 1'b0);
    chkw("b2b_pop_A1", out_data, 32'hA1A1A1A1);
    cyc(1);                                   // stalled B2 written
    chkl("b2b_B2_level", fifo_level, 3'd4);
    chk1("b2b_B2_ready", result_ready, 1'b0);
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
    chkw("b2b_pop_A2", out_data, 32'hA2A2A2A2);
    chk1("b2b_A2_ready", result_ready, 1'b0);
    cyc(1);                                   // B3 written, back to IDLE
    chkl("b2b_B3_level", fifo_level, 3'd4);
    chk1("b2b_B3_ready", result_ready, 1'b1);
    chk1("b2b_B3_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      cyc(1);
      chkw($sformatf("b2b_drain%0d", i), out_data, exp_w[i]);
`ifdef RESULT_SER_LAST_EN
      chk1($sformatf("b2b_drain%0d_last", i), out_last, (i == 0 || i == 3));
`endif
    end
    rd_req = 1'b0;
    chk1("b2b_empty_end", fifo_empty, 1'b1);
    chk1("b2b_uf_sticky", underflow, 1'b1);
  endtask

  task automatic test_async_reset();
    result = 96'hC3C3C3C3_C2C2C2C2_C1C1C1C1;
    result_valid = 1'b1;
    cyc(1);                                   // accept
    result_valid = 1'b0;
    cyc(2);                                   // C1, C2 written
    chkl("ar_level_pre", fifo_level, 3'd2);
    #2 rst_n = 1'b0;
    #1;
    chk1("ar_ready", result_ready, 1'b1);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_empty", fifo_empty, 1'b1);
    chkl("ar_level", fifo_level, 3'd0);
    chkw("ar_data", out_data, '0);
    chk1("ar_underflow", underflow, 1'b0);
    cyc(1);
    rst_n = 1'b1;
    result = 96'hD3D3D3D3_D2D2D2D2_D1D1D1D1;
    result_valid = 1'b1;
    cyc(1);
    result_valid = 1'b0;
    cyc(3);
    chkl("ar_new_level", fifo_level, 3'd3);
    rd_req = 1'b1;
    cyc(1);
    rd_req = 1'b0;
    chkw("ar_new_word0", out_data, 32'hD1D1D1D1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
